// File: rtl/axis_wait_pkg.sv
// Shared definitions for the axis_wait IP: loader FSM states and default frame geometry.
package axis_wait_pkg;

  localparam int WORD_SIZE   = 8;
  localparam int LENGTH_SIZE = 784;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_frame_loader.sv
// Writes one AXI-Stream packet into the frame RAM, then holds the frame and lends RAM
// read access to the consumer until it releases the frame.
module axis_frame_loader #(
  parameter int  WORD_SIZE   = axis_wait_pkg::WORD_SIZE,
  parameter int  LENGTH_SIZE = axis_wait_pkg::LENGTH_SIZE,
  localparam int ADR_SIZE    = $clog2(LENGTH_SIZE)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WORD_SIZE-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                ram_wr,
  output logic                ram_rd,
  output logic [ADR_SIZE-1:0] ram_adr,
  output logic [WORD_SIZE-1:0] ram_dataIn,
  input  logic                cons_rd,
  input  logic [ADR_SIZE-1:0] cons_adr,
  output logic                frame_valid,
  input  logic                frame_release,
  output logic [ADR_SIZE:0]   frame_len,
  output logic                short_frame,
  output logic                overrun
);
  import axis_wait_pkg::*;

  localparam logic [ADR_SIZE:0] FULL_CNT = (ADR_SIZE+1)'(LENGTH_SIZE);
  localparam logic [ADR_SIZE:0] LAST_CNT = (ADR_SIZE+1)'(LENGTH_SIZE - 1);

  state_t              state_r, state_s;
  logic [ADR_SIZE:0]   wr_cnt_r, wr_cnt_s;
  logic [ADR_SIZE:0]   frame_len_r, frame_len_s;
  logic                short_frame_r, short_frame_s;
  logic                overrun_r, overrun_s;
  logic                accept_s;
  logic [ADR_SIZE:0]   cnt_inc_s;

  assign s_axis_tready = ((state_r == LOAD) || (state_r == DRAIN)) & rstn;
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign cnt_inc_s     = wr_cnt_r + (ADR_SIZE+1)'(1);
  assign ram_dataIn    = s_axis_tdata;
  assign frame_valid   = (state_r == HOLD);
  assign frame_len     = frame_len_r;
  assign short_frame   = short_frame_r;
  assign overrun       = overrun_r;

  // RAM port mux: writes only in LOAD, reads only for the consumer in HOLD, so they never overlap.
  always_comb begin
    ram_wr  = 1'b0;
    ram_rd  = 1'b0;
    ram_adr = wr_cnt_r[ADR_SIZE-1:0];
    if (state_r == HOLD) begin
      ram_rd  = cons_rd;
      ram_adr = cons_adr;
    end else if (state_r == LOAD) begin
      ram_wr  = accept_s;
    end else begin
      ram_wr  = 1'b0;
    end
  end

  // Next-state and frame bookkeeping; tlast is checked first so a tlast on the final slot is a normal frame.
  always_comb begin
    state_s       = state_r;
    wr_cnt_s      = wr_cnt_r;
    frame_len_s   = frame_len_r;
    short_frame_s = short_frame_r;
    overrun_s     = overrun_r;
    case (state_r)
      LOAD: begin
        if (accept_s) begin
          wr_cnt_s = cnt_inc_s;
          if (s_axis_tlast) begin
            frame_len_s   = cnt_inc_s;
            short_frame_s = (cnt_inc_s != FULL_CNT);
            state_s       = HOLD;
          end else if (wr_cnt_r == LAST_CNT) begin
            frame_len_s = FULL_CNT;
            overrun_s   = 1'b1;
            state_s     = DRAIN;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      DRAIN: begin
        if (accept_s && s_axis_tlast) begin
          state_s = HOLD;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        if (frame_release) begin
          state_s       = LOAD;
          wr_cnt_s      = '0;
          frame_len_s   = '0;
          short_frame_s = 1'b0;
          overrun_s     = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s       = LOAD;
        wr_cnt_s      = '0;
        frame_len_s   = '0;
        short_frame_s = 1'b0;
        overrun_s     = 1'b0;
      end
    endcase
  end

  // State and frame registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= LOAD;
      wr_cnt_r      <= '0;
      frame_len_r   <= '0;
      short_frame_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      wr_cnt_r      <= wr_cnt_s;
      frame_len_r   <= frame_len_s;
      short_frame_r <= short_frame_s;
      overrun_r     <= overrun_s;
    end
  end

endmodule

// File: tb/tb_axis_frame_loader.sv
// Randomised bench for axis_frame_loader: a packet-level reference model feeds a scoreboard
// that a monitor checks against a bench-side model of the frame RAM.
module tb_axis_frame_loader;
  localparam int W = 8;
  localparam int L = 784;
  localparam int A = $clog2(L);

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic         ram_wr, ram_rd;
  logic [A-1:0] ram_adr;
  logic [W-1:0] ram_dataIn;
  logic         cons_rd = 1'b0;
  logic [A-1:0] cons_adr = '0;
  logic         frame_valid;
  logic         frame_release = 1'b0;
  logic [A:0]   frame_len;
  logic         short_frame, overrun;

  axis_frame_loader dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_adr(ram_adr), .ram_dataIn(ram_dataIn),
    .cons_rd(cons_rd), .cons_adr(cons_adr),
    .frame_valid(frame_valid), .frame_release(frame_release),
    .frame_len(frame_len), .short_frame(short_frame), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard: one entry per completed packet, plus the words that must be in RAM.
  int          exp_len_q[$];
  bit          exp_short_q[$];
  bit          exp_over_q[$];
  byte unsigned exp_word_q[$];

  // Bench-side frame RAM and protocol-violation counters.
  logic [W-1:0] mem [1024];
  bit           written [1024];
  int           both_cnt = 0;
  int           rd_outside = 0;
  bit           tlast_acc = 1'b0;

  always @(posedge clk) begin
    tlast_acc <= s_axis_tvalid & s_axis_tready & s_axis_tlast;
    if (ram_wr && ram_rd) both_cnt <= both_cnt + 1;
    if (ram_rd && !frame_valid) rd_outside <= rd_outside + 1;
    if (!rstn || (frame_release && frame_valid)) begin
      for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
    end else if (ram_wr && !ram_rd) begin
      mem[ram_adr]     <= ram_dataIn;
      written[ram_adr] <= 1'b1;
    end
  end

  // Monitor: on each new held frame, pop the expectation and compare against flags and RAM.
  bit fv_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_valid && !fv_prev) begin
      if (exp_len_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        int elen;
        int bad;
        int stray;
        bad = 0;
        stray = 0;
        elen = exp_len_q.pop_front();
        check("frame_len", int'(frame_len), elen);
        check("short_frame", int'(short_frame), int'(exp_short_q.pop_front()));
        check("overrun", int'(overrun), int'(exp_over_q.pop_front()));
        check("valid_after_tlast", int'(tlast_acc), 1);
        for (int a = 0; a < 1024; a++) begin
          if (a < elen) begin
            byte unsigned ew;
            ew = exp_word_q.pop_front();
            if (!written[a] || mem[a] != ew) bad++;
          end else if (written[a]) begin
            stray++;
          end
        end
        check("ram_contents_bad_words", bad, 0);
        check("ram_writes_beyond_len", stray, 0);
      end
    end
    fv_prev = frame_valid;
  end

  task automatic drive_beat(byte unsigned data, bit last, bit gaps, bit noise);
    int guard;
    if (gaps && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    if (noise) begin
      frame_release = ($urandom_range(0, 7) == 0);
      cons_rd       = $urandom_range(0, 1);
      cons_adr      = A'($urandom_range(0, L - 1));
    end
    guard = 0;
    while (!s_axis_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_axis_tready) check("tready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    frame_release = 1'b0;
    cons_rd       = 1'b0;
  endtask

  // Consumer phase: stream pressure must be refused, reads reach the RAM, release reopens the stream.
  task automatic hold_and_release(int len);
    int guard;
    guard = 0;
    while (!frame_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("frame_valid_timeout", int'(frame_valid), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cons_adr      = (k == 0) ? A'(5) : A'($urandom_range(0, len - 1));
      cons_rd       = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'hEE;
      #1;
      check("hold_tready", int'(s_axis_tready), 0);
      check("hold_ram_rd", int'(ram_rd), 1);
      check("hold_ram_adr", int'(ram_adr), int'(cons_adr));
      check("hold_ram_wr", int'(ram_wr), 0);
    end
    @(negedge clk);
    cons_rd       = 1'b0;
    s_axis_tvalid = 1'b0;
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
    #1;
    check("release_tready", int'(s_axis_tready), 1);
    check("release_frame_valid", int'(frame_valid), 0);
    check("release_flags", int'({frame_len, short_frame, overrun}), 0);
  endtask

  // Reference model: a packet of n words leaves min(n, L) of them in RAM and sets the flags from n.
  task automatic send_packet(int n, int mode, bit gaps, bit noise);
    byte unsigned d[$];
    int keep;
    for (int i = 0; i < n; i++) d.push_back(mode == 0 ? byte'(i % 256) : byte'($urandom_range(0, 255)));
    keep = (n > L) ? L : n;
    exp_len_q.push_back(keep);
    exp_short_q.push_back(n < L);
    exp_over_q.push_back(n > L);
    for (int i = 0; i < keep; i++) exp_word_q.push_back(d[i]);
    for (int i = 0; i < n; i++) drive_beat(d[i], i == n - 1, gaps, noise);
    hold_and_release(keep);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tready", int'(s_axis_tready), 0);
    check("rst_outputs", int'({frame_valid, ram_wr, ram_rd, short_frame, overrun}), 0);
    check("rst_frame_len", int'(frame_len), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("tready_after_reset", int'(s_axis_tready), 1);

    send_packet(L, 0, 1'b0, 1'b0);        // exact frame, index data
    send_packet(10, 1, 1'b0, 1'b0);       // short
    send_packet(L + 6, 1, 1'b0, 1'b0);    // overrun, 6 dropped
    send_packet(L, 0, 1'b1, 1'b0);        // same frame with tvalid gaps
    send_packet(1, 1, 1'b0, 1'b0);        // single beat
    send_packet(L - 1, 1, 1'b1, 1'b0);    // one short of full
    send_packet(L, 1, 1'b0, 1'b1);        // stray release / cons_rd during load
    for (int r = 0; r < 3; r++) send_packet($urandom_range(1, L + 20), 1, 1'b1, 1'b0);

    // Reset in the middle of a load, then a fresh full frame.
    for (int i = 0; i < 300; i++) drive_beat(byte'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midload_rst_tready", int'(s_axis_tready), 0);
    check("midload_rst_valid", int'(frame_valid), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    send_packet(L, 0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_len_q.size(), 0);
    check("wr_rd_overlap", both_cnt, 0);
    check("rd_outside_hold", rd_outside, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_loader.md
# axis_frame_loader

Upstream write stage for the frame buffer RAM in the `axis_wait` IP. It accepts one image frame per AXI-Stream packet, writes each beat into consecutive RAM addresses, and then holds the frame for the CNN-side consumer. During the hold it hands RAM read access to the consumer; it reopens the stream only when the consumer releases the frame. It also flags packets that are shorter or longer than one frame.

## Interface

- `WORD_SIZE`, 8: stream and RAM word width.
- `LENGTH_SIZE`, 784: words per frame (28×28 MNIST); RAM depth.
- `ADR_SIZE`, derived as `$clog2(LENGTH_SIZE)`; localparam, not overridable.

- `clk` in 1: single clock; all logic rises on its positive edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in WORD_SIZE: stream word.
- `s_axis_tvalid` in 1: stream beat valid.
- `s_axis_tlast` in 1: last beat of packet.
- `s_axis_tready` out 1: loader accepts a beat.
- `ram_wr` out 1: RAM write strobe.
- `ram_rd` out 1: RAM read enable.
- `ram_adr` out ADR_SIZE: RAM address.
- `ram_dataIn` out WORD_SIZE: RAM write data, wired to `s_axis_tdata`.
- `cons_rd` in 1: consumer read request, honoured only in HOLD.
- `cons_adr` in ADR_SIZE: consumer read address.
- `frame_valid` out 1: a complete frame is held in RAM.
- `frame_release` in 1: one-cycle pulse; consumer has finished with the frame.
- `frame_len` out ADR_SIZE+1: number of words written for the held frame.
- `short_frame` out 1: `tlast` arrived before `LENGTH_SIZE` words.
- `overrun` out 1: packet exceeded `LENGTH_SIZE` words; excess words were dropped.

## Operation

- The FSM has three states: LOAD, DRAIN and HOLD. Reset state is LOAD. Write counter `wr_cnt` is ADR_SIZE+1 bits and resets to 0.
- A beat is accepted when `s_axis_tvalid & s_axis_tready`.
- `s_axis_tready` = (state is LOAD or DRAIN) & `rstn`.
- LOAD:
  - On an accepted beat, assert `ram_wr` and drive `ram_adr` = `wr_cnt`, then increment `wr_cnt`.
  - If the beat has `tlast`: `frame_len` ← `wr_cnt`+1; `short_frame` ← (`wr_cnt`+1 ≠ LENGTH_SIZE); go to HOLD.
  - Else if `wr_cnt` = LENGTH_SIZE−1: `frame_len` ← LENGTH_SIZE; `overrun` ← 1; go to DRAIN.
- DRAIN: accept and discard beats, keeping `ram_wr` = 0. On an accepted `tlast` beat, go to HOLD.
- HOLD:
  - `frame_valid` = 1 and `s_axis_tready` = 0.
  - `ram_rd` = `cons_rd` and `ram_adr` = `cons_adr`.
  - On `frame_release`: go to LOAD; clear `wr_cnt`, `frame_len`, `short_frame` and `overrun`.
- `frame_release` is ignored outside HOLD. `cons_rd` is ignored outside HOLD, so `ram_rd` = 0 there.
- `ram_wr` and `ram_rd` are never high together. The RAM suppresses a write whenever rd is high, so this exclusion is mandatory.
- Outside LOAD-with-write and HOLD, `ram_adr` = `wr_cnt`[ADR_SIZE-1:0].

## Timing

- Reset values: `frame_valid`, `ram_wr`, `ram_rd`, `short_frame` and `overrun` = 0; `frame_len` = 0; `s_axis_tready` = 0 while `rstn` is low and 1 from the first cycle after deassertion.
- Write path is combinational from the stream. The RAM captures the word on the same edge that accepts the beat, so write latency is 0 cycles.
- `frame_valid` rises on the cycle after the `tlast` beat is accepted.
- `frame_len` and the error flags are valid whenever `frame_valid` = 1.
- Read data comes from the RAM combinationally in the same cycle as `cons_rd`/`cons_adr`.
- After a `frame_release` pulse, `frame_valid` falls and `s_axis_tready` rises on the next cycle, so frames are separated by at least one bubble.
- A `tlast` beat accepted exactly at `wr_cnt` = LENGTH_SIZE−1 is a normal frame: no overrun, `frame_len` = LENGTH_SIZE.
- A single-beat packet gives `frame_len` = 1 and `short_frame` = 1.
- Reset asserted mid-load or mid-hold returns to LOAD with `wr_cnt` = 0 immediately. Partial RAM contents are undefined and are not cleared.

## Structure

- Shared package `axis_wait_pkg`:
  - state enumeration LOAD/DRAIN/HOLD;
  - default constants `WORD_SIZE` = 8 and `LENGTH_SIZE` = 784.
- The block is a single module with no sub-modules; the RAM is instantiated beside it by the IP top.
- The address/read mux lives inside this module.

## Test plan

- 784 beats with data = index mod 256 and `tlast` on beat 783 → `frame_valid` high one cycle after beat 783; `frame_len` = 784; no flags set; RAM[k] = k mod 256.
- 10-beat packet → `frame_len` = 10, `short_frame` = 1; RAM[0..9] written and RAM[10] untouched.
- 790-beat packet → `overrun` = 1, `frame_len` = 784; beats 784–789 are consumed with `s_axis_tready` = 1 and are not written; HOLD is entered after beat 789.
- In HOLD, hold `s_axis_tvalid` high → `s_axis_tready` = 0. Consumer reads address 5 → `ram_rd` = 1, `ram_adr` = 5, `ram_wr` = 0. Pulse `frame_release` → `s_axis_tready` = 1 the next cycle and flags cleared.
- Random `tvalid` gaps across a full frame → frame contents identical to the gap-free case.
- Drop `rstn` after 300 beats → `s_axis_tready` = 0 during reset; after release a fresh 784-beat frame completes with `frame_len` = 784.
